// File: rtl/vga_box_renderer.sv
// ---------------------------------------------------------------------------
// vga_box_renderer
//
// Pixel-generation stage that sits directly behind the VGA timing
// controller. For every pixel address the controller presents, it produces
// a registered 12-bit colour one clock later. A solid square is drawn over
// a flat background. The square moves STEP pixels per frame on each axis and
// bounces off the edges of the visible area. Position changes only on the
// Vsync falling edge, which falls outside the visible area, so a frame is
// never drawn with two different box positions.
//
// Optional feature (compile-time macro VGA_BOX_RENDERER_BORDER_EN):
//   when defined, the outermost ring of visible pixels (X==0,
//   X==H_VISIBLE-1, Y==0, Y==V_VISIBLE-1) is drawn white (12'hFFF). The
//   border takes priority over the box and the background. Latency is
//   still one cycle. When the macro is undefined, no border logic is built.
//
// Ports:
//   clk          in   1   pixel clock, shared with the timing controller
//   rst_n        in   1   synchronous reset, active-low
//   Hsync        in   1   horizontal sync from the controller, active-low
//   Vsync        in   1   vertical sync from the controller, active-low
//   PixelAddress in  20   {X[9:0], Y[9:0]} of the current pixel
//   freeze       in   1   1 = hold box position (frames still counted)
//   RGB          out 12   registered pixel colour {R,G,B}
//   Hsync_out    out  1   Hsync delayed one cycle (aligned with RGB)
//   Vsync_out    out  1   Vsync delayed one cycle (aligned with RGB)
//   frame_tick   out  1   one-cycle pulse per detected frame
//   box_x        out 10   current box left edge
//   box_y        out 10   current box top edge
//   state_dbg    out  1   movement FSM state (0 = ARM, 1 = RUN)
//
// There is no valid/ready handshake. Every clock carries one pixel, and
// the outputs are valid on every cycle after reset.
// ---------------------------------------------------------------------------
module vga_box_renderer #(
    parameter int          H_VISIBLE = 640,
    parameter int          V_VISIBLE = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [19:0] PixelAddress,
    input  logic        freeze,
    output logic [11:0] RGB,
    output logic        Hsync_out,
    output logic        Vsync_out,
    output logic        frame_tick,
    output logic [9:0]  box_x,
    output logic [9:0]  box_y,
    output logic        state_dbg
);

    // Edge arithmetic runs in 11 bits so box+BOX_SIZE+STEP cannot wrap.
    localparam logic [10:0] H_LIM    = 11'(H_VISIBLE);
    localparam logic [10:0] V_LIM    = 11'(V_VISIBLE);
    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  STEP_10  = 10'(STEP);
    localparam logic [9:0]  X_MAX    = 10'(H_VISIBLE - BOX_SIZE);
    localparam logic [9:0]  Y_MAX    = 10'(V_VISIBLE - BOX_SIZE);
    localparam logic [9:0]  X_CENTER = 10'((H_VISIBLE - BOX_SIZE) / 2);
    localparam logic [9:0]  Y_CENTER = 10'((V_VISIBLE - BOX_SIZE) / 2);

    // Direction encodings: 0 = right/down (increasing), 1 = left/up.
    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    // ARM discards the partial frame seen right after reset. RUN moves
    // the box once per frame.
    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic       vs_q;
    logic       frame_ev;
    logic       dir_x, dir_y;
    logic       dir_x_nxt, dir_y_nxt;
    logic [9:0] box_x_nxt, box_y_nxt;
    logic       tick_nxt;

    // Candidate next position/direction if a move is taken this frame.
    logic [9:0] step_x, step_y;
    logic       step_dir_x, step_dir_y;

    // Pixel path.
    logic [9:0]  px, py;
    logic        visible;
    logic        inbox;
    logic [11:0] rgb_nxt;

    // One event per frame: Vsync was high last cycle and is low now.
    assign frame_ev  = vs_q & ~Vsync;
    assign state_dbg = state;

    // ---------------------------------------------------------------
    // Bounce arithmetic. When moving toward an edge, a step that would
    // cross it clamps to the edge and flips direction on the same frame.
    // ---------------------------------------------------------------
    always_comb begin
        step_x     = box_x;
        step_dir_x = dir_x;
        if (dir_x == DIR_INC) begin
            if (({1'b0, box_x} + BOX_W + STEP_W) > H_LIM) begin
                step_x     = X_MAX;
                step_dir_x = DIR_DEC;
            end else begin
                step_x = box_x + STEP_10;
            end
        end else begin
            if ({1'b0, box_x} < STEP_W) begin
                step_x     = '0;
                step_dir_x = DIR_INC;
            end else begin
                step_x = box_x - STEP_10;
            end
        end
    end

    always_comb begin
        step_y     = box_y;
        step_dir_y = dir_y;
        if (dir_y == DIR_INC) begin
            if (({1'b0, box_y} + BOX_W + STEP_W) > V_LIM) begin
                step_y     = Y_MAX;
                step_dir_y = DIR_DEC;
            end else begin
                step_y = box_y + STEP_10;
            end
        end else begin
            if ({1'b0, box_y} < STEP_W) begin
                step_y     = '0;
                step_dir_y = DIR_INC;
            end else begin
                step_y = box_y - STEP_10;
            end
        end
    end

    // ---------------------------------------------------------------
    // Movement FSM: next-state and update decisions.
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        box_x_nxt = box_x;
        box_y_nxt = box_y;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        tick_nxt  = 1'b0;
        case (state)
            ARM: begin
                if (frame_ev) begin
                    tick_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (frame_ev) begin
                    tick_nxt = 1'b1;
                    // freeze still counts the frame but holds the box.
                    if (!freeze) begin
                        box_x_nxt = step_x;
                        box_y_nxt = step_y;
                        dir_x_nxt = step_dir_x;
                        dir_y_nxt = step_dir_y;
                    end
                end
            end
            default: state_nxt = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARM;
            vs_q       <= 1'b1;
            box_x      <= X_CENTER;
            box_y      <= Y_CENTER;
            dir_x      <= DIR_INC;
            dir_y      <= DIR_INC;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            vs_q       <= Vsync;
            box_x      <= box_x_nxt;
            box_y      <= box_y_nxt;
            dir_x      <= dir_x_nxt;
            dir_y      <= dir_y_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Pixel colour decode.
    // ---------------------------------------------------------------
    assign px = PixelAddress[19:10];
    assign py = PixelAddress[9:0];

    assign visible = ({1'b0, px} < H_LIM) && ({1'b0, py} < V_LIM);
    assign inbox   = (px >= box_x) && ({1'b0, px} < ({1'b0, box_x} + BOX_W)) &&
                     (py >= box_y) && ({1'b0, py} < ({1'b0, box_y} + BOX_W));

    always_comb begin
        rgb_nxt = 12'h000;
        if (visible) begin
`ifdef VGA_BOX_RENDERER_BORDER_EN
            if ((px == 10'd0) || ({1'b0, px} == H_LIM - 11'd1) ||
                (py == 10'd0) || ({1'b0, py} == V_LIM - 11'd1)) begin
                rgb_nxt = 12'hFFF;
            end else if (inbox) begin
                rgb_nxt = BOX_COLOR;
            end else begin
                rgb_nxt = BG_COLOR;
            end
`else
            if (inbox) begin
                rgb_nxt = BOX_COLOR;
            end else begin
                rgb_nxt = BG_COLOR;
            end
`endif
        end
    end

    // RGB and the delayed syncs share one register stage, so they stay
    // aligned for the monitor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RGB       <= 12'h000;
            Hsync_out <= 1'b1;
            Vsync_out <= 1'b1;
        end else begin
            RGB       <= rgb_nxt;
            Hsync_out <= Hsync;
            Vsync_out <= Vsync;
        end
    end

endmodule

// File: tb/tb_vga_box_renderer.sv
module tb_vga_box_renderer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in, freeze;
  logic [19:0] pixel_address;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_tick, state_dbg;
  logic [9:0]  box_x, box_y;

  always #5 clk = ~clk;

  vga_box_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Hsync       (hsync_in),
    .Vsync       (vsync_in),
    .PixelAddress(pixel_address),
    .freeze      (freeze),
    .RGB         (rgb),
    .Hsync_out   (hsync_out),
    .Vsync_out   (vsync_out),
    .frame_tick  (frame_tick),
    .box_x       (box_x),
    .box_y       (box_y),
    .state_dbg   (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Box position and signed velocity. "armed" is 0 until the first frame
  // after reset has been seen.
  int m_x, m_y, v_x, v_y;
  bit armed;

  function automatic void model_reset();
    m_x   = (640 - 32) / 2;
    m_y   = (480 - 32) / 2;
    v_x   = 2;
    v_y   = 2;
    armed = 0;
  endfunction

  // Take a step along one axis. A box that would leave [0, lim) is pinned
  // to the edge and its velocity reverses.
  task automatic move_axis(inout int p, inout int v, input int lim);
    int n;
    n = p + v;
    if (n + 32 > lim) begin
      p = lim - 32;
      v = -v;
    end else if (n < 0) begin
      p = 0;
      v = -v;
    end else begin
      p = n;
    end
  endtask

  task automatic model_frame(input bit frz);
    if (!armed) armed = 1;
    else if (!frz) begin
      move_axis(m_x, v_x, 640);
      move_axis(m_y, v_y, 480);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int x, input int y);
    if (x >= 640 || y >= 480) return 12'h000;
`ifdef VGA_BOX_RENDERER_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hFFF;
`endif
    if (x >= m_x && x < m_x + 32 && y >= m_y && y < m_y + 32) return 12'hF00;
    return 12'h00F;
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel with a random Hsync level, then check colour and sync.
  task automatic drive_pixel(input int x, input int y);
    logic hs;
    hs = 1'($urandom_range(0, 1));
    exp_q.push_back(exp_rgb(x, y));
    pixel_address = {10'(x), 10'(y)};
    hsync_in      = hs;
    tick();
    check("rgb", {20'd0, rgb}, {20'd0, exp_q.pop_front()});
    check("hsync_out", {31'd0, hsync_out}, {31'd0, hs});
  endtask

  // One frame: a Vsync low pulse of two cycles, then back high.
  task automatic do_frame(input bit frz);
    freeze   = frz;
    vsync_in = 1'b0;
    model_frame(frz);
    tick();
    check("frame_tick_pulse", {31'd0, frame_tick}, 32'd1);
    check("box_x", {22'd0, box_x}, 32'(m_x));
    check("box_y", {22'd0, box_y}, 32'(m_y));
    check("vsync_out_low", {31'd0, vsync_out}, 32'd0);
    tick();
    check("frame_tick_single", {31'd0, frame_tick}, 32'd0);
    vsync_in = 1'b1;
    tick();
    check("box_x_hold", {22'd0, box_x}, 32'(m_x));
    freeze = 1'b0;
  endtask

  // A few pixels per frame: one anywhere on the raster, one near the box.
  task automatic frame_pixels();
    int x, y;
    drive_pixel($urandom_range(0, 799), $urandom_range(0, 524));
    x = m_x - 1 + $urandom_range(0, 33);
    y = m_y - 1 + $urandom_range(0, 33);
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    drive_pixel(x, y);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int ticks;
    rst_n         = 1'b0;
    hsync_in      = 1'b0;
    vsync_in      = 1'b1;
    freeze        = 1'b0;
    pixel_address = {10'd310, 10'd230};
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_rgb", {20'd0, rgb}, 32'd0);
    check("rst_hsync_out", {31'd0, hsync_out}, 32'd1);
    check("rst_vsync_out", {31'd0, vsync_out}, 32'd1);
    check("rst_box_x", {22'd0, box_x}, 32'd304);
    check("rst_box_y", {22'd0, box_y}, 32'd224);
    check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);
    rst_n    = 1'b1;
    hsync_in = 1'b1;
    tick();

    // Latency: the colour must not change before the next edge.
    pixel_address = {10'd100, 10'd100};
    #2;
    check("latency_hold", {20'd0, rgb}, 32'h00F00);
    tick();
    check("latency_bg", {20'd0, rgb}, 32'h0000F);
    drive_pixel(310, 230);
    check("lat_box_const", {20'd0, rgb}, 32'hF00);
    drive_pixel(700, 10);
    check("lat_blank_const", {20'd0, rgb}, 32'h000);
    drive_pixel(799, 524);

    // Arming frame: tick but no movement.
    do_frame(1'b0);
    check("arm_box_x", {22'd0, box_x}, 32'd304);
    check("run_state", {31'd0, state_dbg}, 32'd1);

    // Right and bottom bounces.
    for (int n = 1; n <= 154; n++) begin
      do_frame(1'b0);
      if (n == 1)   check("x_after_1", {22'd0, box_x}, 32'd306);
      if (n == 112) check("y_after_112", {22'd0, box_y}, 32'd448);
      if (n == 113) check("y_clamp_113", {22'd0, box_y}, 32'd448);
      if (n == 114) check("y_up_114", {22'd0, box_y}, 32'd446);
      if (n == 152) check("x_after_152", {22'd0, box_x}, 32'd608);
      if (n == 153) check("x_clamp_153", {22'd0, box_x}, 32'd608);
      if (n == 154) check("x_left_154", {22'd0, box_x}, 32'd606);
      if (n % 4 == 0) frame_pixels();
    end

    // Random run with occasional freeze; long enough to reach the left
    // and top edges too.
    for (int n = 0; n < 400; n++) begin
      do_frame($urandom_range(0, 7) == 0);
      frame_pixels();
    end

    // Freeze across five frames.
    ticks = 0;
    for (int n = 0; n < 5; n++) begin
      freeze   = 1'b1;
      vsync_in = 1'b0;
      model_frame(1'b1);
      tick();
      if (frame_tick) ticks++;
      tick();
      vsync_in = 1'b1;
      tick();
      check("freeze_box_x", {22'd0, box_x}, 32'(m_x));
      check("freeze_box_y", {22'd0, box_y}, 32'(m_y));
    end
    check("freeze_tick_count", 32'(ticks), 32'd5);
    do_frame(1'b0);
    frame_pixels();

    // Mid-frame reset.
    rst_n    = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    model_reset();
    check("mid_rst_box_x", {22'd0, box_x}, 32'd304);
    check("mid_rst_box_y", {22'd0, box_y}, 32'd224);
    check("mid_rst_state", {31'd0, state_dbg}, 32'd0);
    check("mid_rst_rgb", {20'd0, rgb}, 32'd0);
    check("mid_rst_vsync_out", {31'd0, vsync_out}, 32'd1);
    vsync_in = 1'b1;
    rst_n    = 1'b1;
    tick();
    do_frame(1'b0);
    check("rearm_box_x", {22'd0, box_x}, 32'd304);
    do_frame(1'b0);
    check("resume_box_x", {22'd0, box_x}, 32'd306);

    // Border pixel.
    drive_pixel(0, 200);
`ifdef VGA_BOX_RENDERER_BORDER_EN
    check("border_pixel", {20'd0, rgb}, 32'hFFF);
`else
    check("border_pixel", {20'd0, rgb}, 32'h00F);
`endif
    drive_pixel(639, 479);
    drive_pixel(640, 479);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing controller.
- Consumes the controller's Hsync, Vsync and packed PixelAddress (X in [19:10], Y in [9:0]).
- Produces registered 12-bit RGB, plus sync signals delayed to stay aligned with that RGB.
- Draws a solid square that moves one step per frame and bounces off the visible-area edges. The position updates only during vertical sync, so frames never tear.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
BOX_SIZE, 32, box edge length in pixels
STEP, 2, pixels moved per frame on each axis
BOX_COLOR, 12'hF00, box colour {R[3:0],G[3:0],B[3:0]}
BG_COLOR, 12'h00F, background colour inside the visible area

Ports:
clk  in  1  pixel clock, same clock as the timing controller
rst_n  in  1  synchronous reset, active-low
Hsync  in  1  horizontal sync from the controller, active-low pulse
Vsync  in  1  vertical sync from the controller, active-low pulse
PixelAddress  in  20  {X[9:0], Y[9:0]} of the current pixel
freeze  in  1  1 = hold box position (frames still counted)
RGB  out  12  registered pixel colour
Hsync_out  out  1  Hsync delayed 1 cycle
Vsync_out  out  1  Vsync delayed 1 cycle
frame_tick  out  1  1-cycle pulse per detected frame
box_x  out  10  current box left edge
box_y  out  10  current box top edge

Behaviour:
- Single clock domain. Reset is synchronous and active-low (rst_n sampled on clk rising edge). There are no asynchronous paths.
- Reset values:
  - RGB=0, Hsync_out=1, Vsync_out=1, frame_tick=0.
  - box_x=(H_VISIBLE-BOX_SIZE)/2=304, box_y=(V_VISIBLE-BOX_SIZE)/2=224.
  - dir_x=right, dir_y=down, state=ARM, vs_q=1.
- Frame event: vs_q holds last cycle's Vsync; event = vs_q & ~Vsync (falling edge). Exactly one event per frame.
- State machine:
  - ARM: wait for the first frame event. Position is not updated. On the event, frame_tick=1 and go to RUN. This discards the partial frame after reset.
  - RUN: on each frame event, frame_tick=1 for one cycle. Position and direction update on that same clock edge unless freeze=1.
- X update, moving right:
  - If box_x+BOX_SIZE+STEP > H_VISIBLE: box_x <= H_VISIBLE-BOX_SIZE, dir_x <= left.
  - Else box_x <= box_x+STEP.
- X update, moving left:
  - If box_x < STEP: box_x <= 0, dir_x <= right.
  - Else box_x <= box_x-STEP.
- Y update: same rules as X, using V_VISIBLE, box_y, dir_y (down/up).
- Edge arithmetic: all comparisons in 11-bit unsigned so box_x+BOX_SIZE+STEP cannot wrap.
- Clamp frame: a frame in which a flip occurs leaves the position at the clamped edge value.
- freeze and frame event together: frame_tick still pulses; position and direction are unchanged.
- Pixel path (1-cycle latency): decode X=PixelAddress[19:10], Y=PixelAddress[9:0].
  - visible = X<H_VISIBLE && Y<V_VISIBLE.
  - inbox = box_x<=X<box_x+BOX_SIZE && box_y<=Y<box_y+BOX_SIZE.
  - RGB <= !visible ? 0 : inbox ? BOX_COLOR : BG_COLOR.
  - Hsync_out <= Hsync; Vsync_out <= Vsync.
- Out-of-range addresses (X or Y >= visible, including blanking values up to 799/524) always produce RGB=0.
- Reset mid-operation: on the next edge all outputs return to reset values and state=ARM. Movement resumes only after a fresh Vsync falling edge.

Optional Feature:
- Macro: VGA_BOX_RENDERER_BORDER_EN.
- When defined: visible pixels with X==0, X==H_VISIBLE-1, Y==0 or Y==V_VISIBLE-1 output 12'hFFF. The border has priority over the box and background. Latency stays 1 cycle.
- When undefined: no border logic; edge pixels follow the normal box/background rule.

Test Plan:
1. Reset check: hold rst_n=0 for 3 clocks, then release. Expect RGB=0, Hsync_out=Vsync_out=1, box_x=304, box_y=224, frame_tick=0. No movement until the first Vsync fall, which gives frame_tick and leaves box_x=304.
2. Latency check: PixelAddress={10'd310,10'd230} -> RGB=12'hF00 one cycle later. {10'd100,10'd100} -> 12'h00F. {10'd700,10'd10} -> 12'h000. Hsync_out/Vsync_out equal inputs delayed 1 cycle.
3. Right bounce: in RUN, after 1 frame box_x=306. After 152 frames box_x=608. Frame 153: box_x=608, dir left. Frame 154: box_x=606.
4. Bottom bounce: after 112 frames box_y=448. Frame 113: box_y=448, dir up. Frame 114: box_y=446.
5. Freeze: freeze=1 across 5 Vsync falls -> 5 frame_tick pulses, box_x/box_y unchanged. Release, next frame -> advances by STEP.
6. Mid-run reset and border: assert rst_n=0 mid-frame -> box returns to 304/224 and state=ARM. With VGA_BOX_RENDERER_BORDER_EN, {10'd0,10'd200} -> 12'hFFF; without it -> 12'h00F.
